// File: rtl/sbox_pkg.sv
// Shared constants for the masked S-box randomness path.
// Parameter defaults for rand_buffer and its handshake interface.
package sbox_pkg;

   localparam int SBOX_RAND_BITS = 18;
   localparam int PRNG_WORD_BITS = 64;
   localparam int RAND_POOL_BITS = 128;

   function automatic int pool_lvl_bits(input int pool);
      return $clog2(pool + 1);
   endfunction

endpackage

// File: rtl/rand_buffer_if.sv
// PRNG-side and S-box-side valid/ready handshakes of rand_buffer.
// slave: the buffer; master: PRNG source plus S-box consumer.
interface rand_buffer_if
   import sbox_pkg::*;
#(
   parameter int IN_BITS  = PRNG_WORD_BITS,
   parameter int OUT_BITS = SBOX_RAND_BITS
);

   logic                in_valid;
   logic [IN_BITS-1:0]  in_data;
   logic                in_ready;
   logic                out_valid;
   logic [OUT_BITS-1:0] out_data;
   logic                out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready
   );

endinterface

// File: rtl/rand_health_check.sv
// Stuck/zero PRNG word detector; only built with RAND_HEALTH_EN defined.
// ok_o is combinational on the offered word, err_o is sticky until rst.
`ifdef RAND_HEALTH_EN
module rand_health_check #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         take_i,
   input  logic [W-1:0] word_i,
   output logic         ok_o,
   output logic         err_o
);

   logic [W-1:0] hist_q, hist_d;
   logic         err_q, err_d;
   logic         bad;

   assign bad   = (word_i == hist_q) | (word_i == '0);
   assign ok_o  = ~bad;
   assign err_o = err_q;

   always_comb begin
      hist_d = hist_q;
      err_d  = err_q;
      if (take_i) begin
         hist_d = word_i;
         if (bad) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         err_q  <= 1'b0;
      end else begin
         hist_q <= hist_d;
         err_q  <= err_d;
      end
   end

endmodule
`endif

// File: rtl/rand_buffer.sv
// Bit-pool FIFO re-chunking PRNG words into S-box randomness grants.
// Define RAND_HEALTH_EN to drop stuck/zero words and flag health_err.
module rand_buffer
   import sbox_pkg::*;
#(
   parameter int IN_BITS   = PRNG_WORD_BITS,
   parameter int OUT_BITS  = SBOX_RAND_BITS,
   parameter int POOL_BITS = RAND_POOL_BITS,
   localparam int LW       = $clog2(POOL_BITS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   rand_buffer_if.slave  bus,
   output logic [LW-1:0] level,
   output logic          health_err
);

   localparam logic [LW-1:0] RDY_MAX = LW'(POOL_BITS - IN_BITS);
   localparam logic [LW-1:0] OUT_LV  = LW'(OUT_BITS);
   localparam logic [LW-1:0] IN_LV   = LW'(IN_BITS);

   logic [POOL_BITS-1:0] pool_q, pool_d;
   logic [LW-1:0]        level_q, level_d;
   logic [POOL_BITS-1:0] base_pool, word_ext;
   logic [LW-1:0]        base_lvl;
   logic                 take, give, keep;

   assign bus.in_ready  = (level_q <= RDY_MAX);
   assign bus.out_valid = (level_q >= OUT_LV);
   assign bus.out_data  = pool_q[OUT_BITS-1:0];
   assign level         = level_q;

   // flush wins, so a flushed word never touches the history either
   assign take = bus.in_valid & bus.in_ready & ~flush;
   assign give = bus.out_valid & bus.out_ready;

`ifdef RAND_HEALTH_EN
   rand_health_check #(
      .W(IN_BITS)
   ) u_health (
      .clk    (clk),
      .rst    (rst),
      .take_i (take),
      .word_i (bus.in_data),
      .ok_o   (keep),
      .err_o  (health_err)
   );
`else
   assign keep       = 1'b1;
   assign health_err = 1'b0;
`endif

   always_comb begin
      base_pool = pool_q;
      base_lvl  = level_q;
      word_ext  = POOL_BITS'(bus.in_data);
      if (give) begin
         base_pool = pool_q >> OUT_BITS;
         base_lvl  = level_q - OUT_LV;
      end
      pool_d  = base_pool;
      level_d = base_lvl;
      // new word lands right above what survives this cycle's grant
      if (take && keep) begin
         pool_d  = base_pool | (word_ext << base_lvl);
         level_d = base_lvl + IN_LV;
      end
      if (flush) begin
         pool_d  = '0;
         level_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pool_q  <= '0;
         level_q <= '0;
      end else begin
         pool_q  <= pool_d;
         level_q <= level_d;
      end
   end

endmodule

// File: tb/tb_rand_buffer.sv
// Bench for rand_buffer: bit-queue reference model, directed anchors,
// then randomized traffic with flushes and a mid-run reset.
module tb_rand_buffer;
   import sbox_pkg::*;

   localparam int IW = 64;
   localparam int OW = 18;
   localparam int PW = 128;
   localparam int LW = $clog2(PW + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic [LW-1:0] level;
   logic          health_err;

   rand_buffer_if #(.IN_BITS(IW), .OUT_BITS(OW)) bus ();

   rand_buffer #(
      .IN_BITS(IW), .OUT_BITS(OW), .POOL_BITS(PW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus),
      .level(level), .health_err(health_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // reference: pool as a queue of bits, front = oldest
   bit pq[$];
   bit herr_m = 1'b0;
`ifdef RAND_HEALTH_EN
   logic [IW-1:0] hist_m = '0;
`endif

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pq.delete();
         herr_m = 1'b0;
`ifdef RAND_HEALTH_EN
         hist_m = '0;
`endif
      end else begin
         bit rdy, vld, ok;
         rdy = pq.size() <= PW - IW;
         vld = pq.size() >= OW;
         if (flush) pq.delete();
         else begin
            if (bus.out_ready && vld)
               repeat (OW) void'(pq.pop_front());
            if (bus.in_valid && rdy) begin
               ok = 1'b1;
`ifdef RAND_HEALTH_EN
               if (bus.in_data == hist_m || bus.in_data == '0) begin
                  ok = 1'b0;
                  herr_m = 1'b1;
               end
               hist_m = bus.in_data;
`endif
               if (ok)
                  for (int i = 0; i < IW; i++) pq.push_back(bus.in_data[i]);
            end
         end
      end
   end

   function automatic logic [OW-1:0] m_out();
      logic [OW-1:0] r;
      r = '0;
      for (int i = 0; i < OW; i++)
         if (i < pq.size()) r[i] = pq[i];
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         chk("level", 64'(level), 64'(pq.size()));
         chk("in_ready", 64'(bus.in_ready), 64'(pq.size() <= PW - IW));
         chk("out_valid", 64'(bus.out_valid), 64'(pq.size() >= OW));
         chk("out_data", 64'(bus.out_data), 64'(m_out()));
         chk("health_err", 64'(health_err), 64'(herr_m));
      end
   end

   task automatic drive(logic v, logic [IW-1:0] d, logic r, logic f);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      flush         = f;
      @(negedge clk);
   endtask

   localparam logic [IW-1:0] WA = 64'hFEDCBA9876543210;
   localparam logic [IW-1:0] WB = 64'hC3A55A3C0F1E2D4B;
   localparam logic [IW-1:0] WC = 64'h0BADF00D12345678;
   localparam logic [IW-1:0] WW = 64'h1122334455667788;
   localparam logic [IW-1:0] WD = 64'h5A5A1234C0DE0001;

   initial begin
      int words, cons;
      logic [IW-1:0] prev, d;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_health", 64'(health_err), 64'd0);

      drive(1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
      chk("w1_level", 64'(level), 64'd64);
      chk("w1_out_valid", 64'(bus.out_valid), 64'd1);
      chk("w1_out_data", 64'(bus.out_data), 64'h3CDEF);
      chk("w1_model_lvl", 64'(pq.size()), 64'd64);
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("c1_out_data", 64'(bus.out_data), 64'h1E26A);
      chk("c1_level", 64'(level), 64'd46);
      chk("c1_model_out", 64'(m_out()), 64'h1E26A);

      drive(1'b0, '0, 1'b0, 1'b1);
      chk("fl_level", 64'(level), 64'd0);
      drive(1'b1, WA, 1'b0, 1'b0);
      drive(1'b1, WB, 1'b0, 1'b0);
      chk("full_level", 64'(level), 64'd128);
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      drive(1'b1, WC, 1'b0, 1'b0);
      chk("drop_level", 64'(level), 64'd128);
      repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
      chk("c4_level", 64'(level), 64'd56);
      chk("c4_in_ready", 64'(bus.in_ready), 64'd1);

      repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
      chk("l20_level", 64'(level), 64'd20);
      drive(1'b1, WW, 1'b1, 1'b0);
      chk("sim_level", 64'(level), 64'd66);
      chk("sim_out_data", 64'(bus.out_data), 64'h1DE23);

      drive(1'b0, '0, 1'b0, 1'b1);
      words = 0;
      cons  = 0;
      for (int c = 0; c < 200 && !(words == 10 && cons == 30); c++) begin
         if (words < 10 && pq.size() <= PW - IW) begin
            drive(1'b1, {32'(c + 1), $urandom}, 1'b0, 1'b0);
            words++;
         end else begin
            drive(1'b0, '0, 1'b1, 1'b0);
            cons++;
         end
      end
      chk("l100_level", 64'(level), 64'd100);
      drive(1'b1, WW, 1'b1, 1'b1);
      chk("flush_level", 64'(level), 64'd0);
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);

      drive(1'b1, WD, 1'b0, 1'b0);
      drive(1'b1, WD, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
`ifdef RAND_HEALTH_EN
      chk("dup_level", 64'(level), 64'd64);
      chk("dup_health", 64'(health_err), 64'd1);
`else
      chk("dup_level", 64'(level), 64'd128);
      chk("dup_health", 64'(health_err), 64'd0);
`endif

      prev = WD;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            #2 rst = 1'b1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            flush         = 1'b0;
            @(negedge clk);
            chk("mid_rst_level", 64'(level), 64'd0);
            chk("mid_rst_health", 64'(health_err), 64'd0);
            rst = 1'b0;
         end
         case ($urandom % 8)
            0: d = prev;
            1: d = '0;
            default: d = {$urandom, $urandom};
         endcase
         if ($urandom % 4 != 0) prev = d;
         drive(($urandom % 4) != 0, d, ($urandom % 3) != 0,
               ($urandom % 97) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rand_buffer.md
RAND_BUFFER -- requirements
Module: rand_buffer

Interface
REQ-001 Parameter IN_BITS, default 64, SHALL be the width of one PRNG stream word accepted per transfer.
REQ-002 Parameter OUT_BITS, default 18, SHALL be the width of one randomness grant, i.e. one masked S-box rand vector.
REQ-003 Parameter POOL_BITS, default 128, SHALL be the bit-pool capacity; legal only if POOL_BITS >= IN_BITS + OUT_BITS.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 flush  input  1  SHALL be a synchronous pool discard, used on PRNG reseed.
REQ-007 in_valid  input  1  SHALL mean in_data holds a valid PRNG word.
REQ-008 in_data  input  IN_BITS  SHALL be the PRNG stream word; bit 0 is the oldest bit.
REQ-009 in_ready  output  1  SHALL mean the pool can take one whole word this cycle.
REQ-010 out_valid  output  1  SHALL mean out_data holds OUT_BITS fresh bits.
REQ-011 out_data  output  OUT_BITS  SHALL be the grant; bit 0 is the oldest pool bit.
REQ-012 out_ready  input  1  SHALL mean the S-box stage consumes the grant this cycle.
REQ-013 level  output  $clog2(POOL_BITS+1)  SHALL be the number of valid bits in the pool.
REQ-014 health_err  output  1  SHALL be the sticky source-fault flag (REQ-026).

Function
REQ-015 Pool SHALL be a bit FIFO; accepted words append above existing bits, with in_data[0] placed first.
REQ-016 in_ready SHALL equal (level <= POOL_BITS-IN_BITS), derived from registered level only, with no dependence on out_ready.
REQ-017 Word accept SHALL occur iff in_valid & in_ready; words offered while in_ready=0 are dropped. The source is a free-running PRNG and is not stalled.
REQ-018 out_valid SHALL equal (level >= OUT_BITS); out_data SHALL be pool[OUT_BITS-1:0].
REQ-019 Grant consume SHALL occur iff out_valid & out_ready; the pool shifts down by OUT_BITS.
REQ-020 Simultaneous accept and consume SHALL apply both in one cycle: level_next = level + IN_BITS - OUT_BITS, with the new word placed directly above the remaining bits.
REQ-021 Latency: a word accepted at edge N SHALL be visible on out_data after edge N; no combinational path from in_data to out_data.
REQ-022 Bits above level SHALL be zero; a granted bit SHALL never be granted twice.
REQ-023 flush SHALL clear the pool and set level=0, overriding any same-cycle accept or consume; health_err is unaffected.
REQ-024 level SHALL never exceed POOL_BITS or underflow.

Reset
REQ-025 On rst: pool=0, level=0, in_ready=1, out_valid=0, out_data=0, health_err=0; the word-history register is cleared.

Configuration
REQ-026 With RAND_HEALTH_EN defined: an accepted word equal to the previously accepted word, or equal to all-zero, SHALL be discarded (not appended), and health_err SHALL set and hold until rst.
REQ-027 Without RAND_HEALTH_EN: health_err SHALL be tied 0, no history register exists, and all accepted words are appended.

Structure
REQ-028 Shared package sbox_pkg SHALL hold the SBOX_RAND_BITS=18 and PRNG_WORD_BITS=64 constants used as parameter defaults.
REQ-029 A single sub-module rand_health_check (stuck/zero-word detector) SHALL be instantiated only under RAND_HEALTH_EN; the pool datapath stays in rand_buffer.

Verification
REQ-030 Reset, then in_valid=1 with in_data=64'h0123456789ABCDEF for one cycle -> level=64, out_valid=1, out_data=18'h3CDEF.
REQ-031 Continuing REQ-030, out_ready=1 for one cycle -> out_data=18'h1E26A, level=46.
REQ-032 Two words accepted back-to-back, no consume -> level=128, in_ready=0; a third offered word is dropped; after 4 consumes, level=56 and in_ready=1.
REQ-033 in_valid=1 and out_ready=1 simultaneously at level=20 -> level=66, and the next grant is the 2 leftover bits followed by the new word's bits [15:0].
REQ-034 flush asserted with in_valid=1 and out_ready=1 at level=100 -> level=0, out_valid=0.
REQ-035 RAND_HEALTH_EN: the same word offered twice -> the second is not appended (level=64), health_err=1 until rst; macro off -> level=128, health_err=0.
